// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_t;

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result bundle of the sequential adder, with producer (master) and adder (slave) views.
interface cla_seq_adder_ctrl_if #(
  parameter int WIDTH = 32
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_*: the producer holds a/b/cin with in_valid until in_ready is seen.
  // out_*: sum/cout/out_valid stay stable until out_ready completes the transfer.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/cla_seq_adder_ctrl_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with fully expanded carries.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// WIDTH-bit adder that reuses one 4-bit lookahead slice over the operands, LSB nibble first.
module cla_seq_adder_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_seq_adder_ctrl_if.slave bus,
  output cla_seq_state_t      dbg_state
);

  localparam int NSLICE = WIDTH / NIB;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  cla_seq_state_t   state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  // NIB is 4, so the bit offset of nibble idx is idx with two zero LSBs appended.
  logic [IDX_W+1:0] bit_base;
  logic [NIB-1:0]   nib_sum;
  logic             nib_cout;

  assign bit_base = {idx, 2'b00};

  cla4_slice u_slice (
    .a    (a_q[bit_base +: NIB]),
    .b    (b_q[bit_base +: NIB]),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            carry_q    <= bus.cin;
            sum_q      <= '0;
            idx        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[bit_base +: NIB] <= nib_sum;
          carry_q                <= nib_cout;
          // idx parks on the last nibble instead of wrapping.
          if (idx == IDX_LAST) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = carry_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for the nibble-serial adder: directed cases on a 32-bit build, random traffic on an 8-bit build.
module tb_cla_seq_adder_ctrl;
  import cla_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_seq_adder_ctrl_if #(.WIDTH(32)) m32 ();
  cla_seq_adder_ctrl_if #(.WIDTH(8))  m8 ();
  cla_seq_state_t st32;
  cla_seq_state_t st8;

  cla_seq_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m32),
    .dbg_state (st32)
  );

  cla_seq_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m8),
    .dbg_state (st8)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition, carry out is the extra top bit.
  function automatic logic [32:0] ref_add32(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin);
    return {1'b0, a} + {1'b0, b} + 33'(cin);
  endfunction

  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + 9'(cin);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int guard;
    guard = 0;
    m32.a        = a;
    m32.b        = b;
    m32.cin      = cin;
    m32.in_valid = 1'b1;
    while (!m32.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("accept_wait", 64'(guard < 100), 64'(1));
    tick();
    m32.in_valid = 1'b0;
  endtask

  task automatic wait_out32(output int lat);
    lat = 0;
    while (!m32.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic take32(output logic [31:0] s, output logic c);
    s = m32.sum;
    c = m32.cout;
    m32.out_ready = 1'b1;
    tick();
    m32.out_ready = 1'b0;
  endtask

  task automatic run_op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin);
    int          lat;
    logic [31:0] s;
    logic        c;
    logic [32:0] e;
    e = ref_add32(a, b, cin);
    send32(a, b, cin);
    wait_out32(lat);
    check({tag, "_latency"}, 64'(lat), 64'(8));
    take32(s, c);
    check({tag, "_sum"}, 64'(s), 64'(e[31:0]));
    check({tag, "_cout"}, 64'(c), 64'(e[32]));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] s;
    logic        c;
    logic [32:0] e;
    logic [31:0] ops_a[3];
    logic [31:0] ops_b[3];
    logic        ops_c[3];
    int          acc_cyc[3];
    int          k_in;
    int          k_out;
    int          cyc;
    int          n_done;
    logic        acc;
    logic        fin;
    logic [8:0]  e8;

    m32.in_valid = 1'b0; m32.a = '0; m32.b = '0; m32.cin = 1'b0; m32.out_ready = 1'b0;
    m8.in_valid  = 1'b0; m8.a  = '0; m8.b  = '0; m8.cin  = 1'b0; m8.out_ready  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // reset state
    check("rst_in_ready",  64'(m32.in_ready),  64'(1));
    check("rst_out_valid", 64'(m32.out_valid), 64'(0));
    check("rst_busy",      64'(m32.busy),      64'(0));
    check("rst_sum",       64'(m32.sum),       64'(0));
    check("rst_cout",      64'(m32.cout),      64'(0));
    check("rst_state",     64'(st32),          64'(IDLE));

    // T1: basic add, with status checks in RUN and after the handshake
    e = ref_add32(32'h12345678, 32'h9ABCDEF0, 1'b1);
    send32(32'h12345678, 32'h9ABCDEF0, 1'b1);
    check("t1_busy_run",     64'(m32.busy),     64'(1));
    check("t1_in_ready_run", 64'(m32.in_ready), 64'(0));
    check("t1_state_run",    64'(st32),         64'(RUN));
    wait_out32(lat);
    check("t1_latency", 64'(lat), 64'(8));
    take32(s, c);
    check("t1_sum",  64'(s), 64'(e[31:0]));
    check("t1_cout", 64'(c), 64'(e[32]));
    check("t1_in_ready_after", 64'(m32.in_ready),  64'(1));
    check("t1_out_valid_after", 64'(m32.out_valid), 64'(0));
    check("t1_sum_held",        64'(m32.sum),       64'(e[31:0]));

    // T2: carry ripples through every nibble
    run_op32("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

    // T3: backpressure with an ignored input during the stall
    e = ref_add32(32'hDEAD_BEEF, 32'h1357_2468, 1'b1);
    send32(32'hDEAD_BEEF, 32'h1357_2468, 1'b1);
    wait_out32(lat);
    check("t3_latency", 64'(lat), 64'(8));
    m32.a = 32'h1; m32.b = 32'h1; m32.cin = 1'b0; m32.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_valid",    64'(m32.out_valid), 64'(1));
      check("t3_stall_sum",      64'(m32.sum),       64'(e[31:0]));
      check("t3_stall_cout",     64'(m32.cout),      64'(e[32]));
      check("t3_stall_in_ready", 64'(m32.in_ready),  64'(0));
    end
    m32.in_valid = 1'b0;
    take32(s, c);
    check("t3_sum",  64'(s), 64'(e[31:0]));
    check("t3_cout", 64'(c), 64'(e[32]));
    repeat (3) tick();
    check("t3_no_phantom_op", 64'(st32), 64'(IDLE));
    check("t3_sum_kept",      64'(m32.sum), 64'(e[31:0]));

    // T4: asynchronous reset in the middle of an operation
    send32(32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_out_valid", 64'(m32.out_valid), 64'(0));
    check("t4_busy",      64'(m32.busy),      64'(0));
    check("t4_in_ready",  64'(m32.in_ready),  64'(1));
    check("t4_sum",       64'(m32.sum),       64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op32("t4_next", 32'h1, 32'h2, 1'b0);

    // T5: back-to-back with in_valid and out_ready held high
    ops_a[0] = 32'h0;         ops_b[0] = 32'h0;         ops_c[0] = 1'b1;
    ops_a[1] = 32'h8000_0000; ops_b[1] = 32'h8000_0000; ops_c[1] = 1'b0;
    ops_a[2] = 32'h0F0F_0F0F; ops_b[2] = 32'hF0F0_F0F0; ops_c[2] = 1'b1;
    k_in = 0; k_out = 0; cyc = 0;
    m32.a = ops_a[0]; m32.b = ops_b[0]; m32.cin = ops_c[0];
    m32.in_valid = 1'b1; m32.out_ready = 1'b1;
    while (k_out < 3 && cyc < 200) begin
      acc = m32.in_valid && m32.in_ready;
      fin = m32.out_valid && m32.out_ready;
      if (fin) begin
        e = ref_add32(ops_a[k_out], ops_b[k_out], ops_c[k_out]);
        check("t5_sum",  64'(m32.sum),  64'(e[31:0]));
        check("t5_cout", 64'(m32.cout), 64'(e[32]));
        k_out++;
      end
      tick();
      cyc++;
      if (acc) begin
        acc_cyc[k_in] = cyc;
        k_in++;
        if (k_in < 3) begin
          m32.a = ops_a[k_in]; m32.b = ops_b[k_in]; m32.cin = ops_c[k_in];
        end else begin
          m32.in_valid = 1'b0;
        end
      end
    end
    m32.in_valid  = 1'b0;
    m32.out_ready = 1'b0;
    check("t5_all_results", 64'(k_out), 64'(3));
    if (k_in == 3) begin
      check("t5_spacing_01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(10));
      check("t5_spacing_12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(10));
    end else begin
      check("t5_all_accepts", 64'(k_in), 64'(3));
    end
    tick();

    // T6: random throttled traffic on the 8-bit build
    n_done = 0; cyc = 0;
    m8.a = 8'($urandom); m8.b = 8'($urandom); m8.cin = 1'($urandom);
    m8.in_valid  = ($urandom_range(0, 3) != 0);
    m8.out_ready = ($urandom_range(0, 3) != 0);
    while (n_done < 1000 && cyc < 40000) begin
      acc = m8.in_valid && m8.in_ready;
      fin = m8.out_valid && m8.out_ready;
      if (fin) begin
        check("t6_pending", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e8 = exp_q.pop_front();
          check("t6_result", 64'({m8.cout, m8.sum}), 64'(e8));
        end
        n_done++;
      end
      if (acc) exp_q.push_back(ref_add8(m8.a, m8.b, m8.cin));
      tick();
      cyc++;
      if (acc) begin
        m8.a = 8'($urandom); m8.b = 8'($urandom); m8.cin = 1'($urandom);
      end
      m8.in_valid  = ($urandom_range(0, 3) != 0);
      m8.out_ready = ($urandom_range(0, 3) != 0);
    end
    m8.in_valid  = 1'b0;
    m8.out_ready = 1'b0;
    check("t6_ops_done", 64'(n_done), 64'(1000));

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
